// File: rtl/scaler_pkg.sv
// Shared scaler definitions: line-bank count default, FIFO occupancy states
// and the ring-pointer wrap helper.
package scaler_pkg;

   localparam int LINE_NUM_DEF = 4;

   typedef enum logic [1:0] {
      FIFO_EMPTY,
      FIFO_PRIME,
      FIFO_READY,
      FIFO_FULL
   } fifoState_t;

   // Bank count is a power of two, so wrapping is a mask.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned lineNum);
      return (ptr + 1) & (lineNum - 1);
   endfunction

endpackage

// File: rtl/line_ptr_cnt.sv
// Write/read line pointers and occupancy counter for the line-bank ring,
// including the jmp/rdReq accept rules and the sticky overflow/underflow flags.
module line_ptr_cnt
   import scaler_pkg::*;
#(
   parameter int LINE_NUM  = LINE_NUM_DEF,
   parameter int PTR_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 jmp,
   input  logic                 rdReq,
   input  logic                 frmEnd,
   input  logic                 ramWrtEn,
   output logic [PTR_WIDTH-1:0] wrPtr,
   output logic [PTR_WIDTH-1:0] rdPtr,
   output logic [PTR_WIDTH:0]   cnt,
   output fifoState_t           state,
   output logic                 ovf,
   output logic                 udf
);

   localparam logic [PTR_WIDTH:0] CNT_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(LINE_NUM);

   logic full;
   logic rdValid;
   logic jmpOk;
   logic rdOk;

   always_comb begin
      state = FIFO_READY;
      if (cnt == '0)
         state = FIFO_EMPTY;
      else if (cnt == CNT_ONE)
         state = FIFO_PRIME;
      else if (cnt == CNT_FULL)
         state = FIFO_FULL;
   end

   // Acceptance is judged on the pre-edge count, so a full ring still
   // rejects a jmp even when a coincident rdReq frees a line.
   assign full    = (state == FIFO_FULL);
   assign rdValid = (state == FIFO_READY) || (state == FIFO_FULL);
   assign jmpOk   = jmp && !full;
   assign rdOk    = rdReq && rdValid;

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else if (frmEnd) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (jmpOk)
            wrPtr <= PTR_WIDTH'(ptr_inc(32'(wrPtr), LINE_NUM));
         if (rdOk)
            rdPtr <= PTR_WIDTH'(ptr_inc(32'(rdPtr), LINE_NUM));
         if (jmpOk && !rdOk)
            cnt <= cnt + CNT_ONE;
         else if (rdOk && !jmpOk)
            cnt <= cnt - CNT_ONE;
         if (full && (jmp || ramWrtEn))
            ovf <= 1'b1;
         if (rdReq && !rdValid)
            udf <= 1'b1;
      end
   end

endmodule

// File: rtl/line_fifo_ctrl.sv
// Line-buffer bank scheduler: steers writer traffic into the current write
// bank and presents the calculator with the registered top/bottom line pair.
module line_fifo_ctrl
   import scaler_pkg::*;
#(
   parameter int DATA_WIDTH    = 24,
   parameter int ADDRESS_WIDTH = 11,
   parameter int LINE_NUM      = LINE_NUM_DEF,
   parameter int PTR_WIDTH     = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ramWrtEn,
   input  logic [ADDRESS_WIDTH-1:0]       ramWrtAddr,
   input  logic [DATA_WIDTH-1:0]          dIn,
   input  logic                           jmp,
   input  logic                           rdReq,
   input  logic                           frmEnd,
   input  logic [LINE_NUM*DATA_WIDTH-1:0] ramRdData,
   output logic [LINE_NUM-1:0]            bankWrtEn,
   output logic [ADDRESS_WIDTH-1:0]       bankWrtAddr,
   output logic [DATA_WIDTH-1:0]          bankWrtData,
   output logic [PTR_WIDTH:0]             fifoNum,
   output logic                           rdValid,
   output logic [DATA_WIDTH-1:0]          rdTopData,
   output logic [DATA_WIDTH-1:0]          rdBotData,
   output logic                           ovf,
   output logic                           udf
);

   logic [PTR_WIDTH-1:0] wrPtr;
   logic [PTR_WIDTH-1:0] rdPtr;
   logic [PTR_WIDTH-1:0] rdPtrNxt;
   fifoState_t           state;
   logic                 wrOk;

   line_ptr_cnt #(
      .LINE_NUM  (LINE_NUM),
      .PTR_WIDTH (PTR_WIDTH)
   ) uPtrCnt (
      .clk      (clk),
      .rst      (rst),
      .jmp      (jmp),
      .rdReq    (rdReq),
      .frmEnd   (frmEnd),
      .ramWrtEn (ramWrtEn),
      .wrPtr    (wrPtr),
      .rdPtr    (rdPtr),
      .cnt      (fifoNum),
      .state    (state),
      .ovf      (ovf),
      .udf      (udf)
   );

   assign rdValid  = (state == FIFO_READY) || (state == FIFO_FULL);
   assign wrOk     = ramWrtEn && (state != FIFO_FULL) && !frmEnd;
   assign rdPtrNxt = PTR_WIDTH'(ptr_inc(32'(rdPtr), LINE_NUM));

   // Write stage: wrPtr is the pre-jump bank even when jmp coincides.
   always_ff @(posedge clk) begin
      if (rst) begin
         bankWrtEn   <= '0;
         bankWrtAddr <= '0;
         bankWrtData <= '0;
      end else begin
         bankWrtEn <= '0;
         if (wrOk) begin
            bankWrtEn   <= LINE_NUM'(1) << wrPtr;
            bankWrtAddr <= ramWrtAddr;
            bankWrtData <= dIn;
         end
      end
   end

   // Read stage: refreshed every cycle, independent of rdValid.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdTopData <= '0;
         rdBotData <= '0;
      end else begin
         rdTopData <= ramRdData[int'(rdPtr)*DATA_WIDTH +: DATA_WIDTH];
         rdBotData <= ramRdData[int'(rdPtrNxt)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_line_fifo_ctrl.sv
// Scoreboard bench for line_fifo_ctrl: directed stimulus queues expected
// writes and status snapshots; a negedge monitor pops and compares them.
module tb_line_fifo_ctrl;

   localparam logic [23:0] B0 = 24'hA00000;
   localparam logic [23:0] B1 = 24'hA11111;
   localparam logic [23:0] B2 = 24'hA22222;
   localparam logic [23:0] B3 = 24'hA33333;

   logic        clk = 1'b0;
   logic        rst;
   logic        ramWrtEn;
   logic [10:0] ramWrtAddr;
   logic [23:0] dIn;
   logic        jmp;
   logic        rdReq;
   logic        frmEnd;
   logic [95:0] ramRdData;
   logic [3:0]  bankWrtEn;
   logic [10:0] bankWrtAddr;
   logic [23:0] bankWrtData;
   logic [2:0]  fifoNum;
   logic        rdValid;
   logic [23:0] rdTopData;
   logic [23:0] rdBotData;
   logic        ovf;
   logic        udf;

   line_fifo_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .ramWrtEn    (ramWrtEn),
      .ramWrtAddr  (ramWrtAddr),
      .dIn         (dIn),
      .jmp         (jmp),
      .rdReq       (rdReq),
      .frmEnd      (frmEnd),
      .ramRdData   (ramRdData),
      .bankWrtEn   (bankWrtEn),
      .bankWrtAddr (bankWrtAddr),
      .bankWrtData (bankWrtData),
      .fifoNum     (fifoNum),
      .rdValid     (rdValid),
      .rdTopData   (rdTopData),
      .rdBotData   (rdBotData),
      .ovf         (ovf),
      .udf         (udf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  en;
      logic [10:0] addr;
      logic [23:0] data;
   } wr_t;

   typedef struct {
      int          tcyc;
      logic [3:0]  en;
      logic [2:0]  fn;
      logic        vld;
      logic        o;
      logic        u;
      logic        chkRd;
      logic [23:0] top;
      logic [23:0] bot;
   } stat_t;

   wr_t   wq[$];
   stat_t sq[$];
   int    nTests = 0;
   int    nFail  = 0;

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops a write whenever the DUT issues one, and any status
   // snapshot scheduled for the current cycle.
   always @(negedge clk) begin
      if (bankWrtEn !== 4'b0000) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", 24'(bankWrtEn), 24'h0);
         end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_en", 24'(bankWrtEn), 24'(w.en));
            chk("wr_addr", 24'(bankWrtAddr), 24'(w.addr));
            chk("wr_data", bankWrtData, w.data);
         end
      end
      while (sq.size() > 0 && sq[0].tcyc <= cyc) begin
         stat_t s;
         s = sq.pop_front();
         chk("stat_cycle", 24'(s.tcyc), 24'(cyc));
         chk("bankWrtEn", 24'(bankWrtEn), 24'(s.en));
         chk("fifoNum", 24'(fifoNum), 24'(s.fn));
         chk("rdValid", 24'(rdValid), 24'(s.vld));
         chk("ovf", 24'(ovf), 24'(s.o));
         chk("udf", 24'(udf), 24'(s.u));
         if (s.chkRd) begin
            chk("rdTopData", rdTopData, s.top);
            chk("rdBotData", rdBotData, s.bot);
         end
      end
   end

   task automatic expS(input int t, input logic [3:0] en, input logic [2:0] fn,
                       input logic vld, input logic o, input logic u,
                       input logic chkRd, input logic [23:0] top, input logic [23:0] bot);
      stat_t s;
      s = '{t, en, fn, vld, o, u, chkRd, top, bot};
      sq.push_back(s);
   endtask

   task automatic expW(input logic [3:0] en, input logic [10:0] a, input logic [23:0] d);
      wr_t w;
      w = '{en, a, d};
      wq.push_back(w);
   endtask

   task automatic cycleIn(input logic j, input logic r, input logic f, input logic w,
                          input logic [10:0] a, input logic [23:0] d);
      jmp = j; rdReq = r; frmEnd = f; ramWrtEn = w; ramWrtAddr = a; dIn = d;
      @(posedge clk); #1;
      jmp = 1'b0; rdReq = 1'b0; frmEnd = 1'b0; ramWrtEn = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycleIn(0, 0, 0, 0, 11'd0, 24'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; jmp = 1'b0; rdReq = 1'b0; frmEnd = 1'b0; ramWrtEn = 1'b0;
      ramWrtAddr = '0; dIn = '0;
      ramRdData = {B3, B2, B1, B0};
      repeat (3) @(posedge clk);
      #1;
      expS(cyc, 4'b0000, 3'd0, 0, 0, 0, 1, 24'h0, 24'h0);
      rst = 1'b0;

      // Two lines, ten cycles apart
      expS(cyc + 1, 4'b0000, 3'd1, 0, 0, 0, 1, B0, B1);
      cycleIn(1, 0, 0, 0, 11'd0, 24'd0);
      idle(9);
      expS(cyc, 4'b0000, 3'd1, 0, 0, 0, 1, B0, B1);
      expS(cyc + 1, 4'b0000, 3'd2, 1, 0, 0, 1, B0, B1);
      cycleIn(1, 0, 0, 0, 11'd0, 24'd0);

      // Writes into bank 2
      for (int i = 0; i < 4; i++) begin
         expS(cyc + 1, 4'b0100, 3'd2, 1, 0, 0, 0, 24'h0, 24'h0);
         expW(4'b0100, 11'(i), 24'h5A0000 + 24'(i));
         cycleIn(0, 0, 0, 1, 11'(i), 24'h5A0000 + 24'(i));
      end

      // Simultaneous jmp and rdReq at fifoNum=2
      expS(cyc + 1, 4'b0000, 3'd2, 1, 0, 0, 0, 24'h0, 24'h0);
      expS(cyc + 2, 4'b0000, 3'd2, 1, 0, 0, 1, B1, B2);
      cycleIn(1, 1, 0, 0, 11'd0, 24'd0);
      idle(1);
      expS(cyc + 1, 4'b1000, 3'd2, 1, 0, 0, 0, 24'h0, 24'h0);
      expW(4'b1000, 11'd7, 24'h123456);
      cycleIn(0, 0, 0, 1, 11'd7, 24'h123456);

      // Drain to one line, then an underflowing rdReq
      expS(cyc + 1, 4'b0000, 3'd1, 0, 0, 0, 0, 24'h0, 24'h0);
      cycleIn(0, 1, 0, 0, 11'd0, 24'd0);
      expS(cyc + 1, 4'b0000, 3'd1, 0, 0, 1, 0, 24'h0, 24'h0);
      cycleIn(0, 1, 0, 0, 11'd0, 24'd0);

      // Fill to three, then frmEnd with jmp
      cycleIn(1, 0, 0, 0, 11'd0, 24'd0);
      expS(cyc + 1, 4'b0000, 3'd3, 1, 0, 1, 0, 24'h0, 24'h0);
      cycleIn(1, 0, 0, 0, 11'd0, 24'd0);
      expS(cyc + 1, 4'b0000, 3'd0, 0, 0, 1, 0, 24'h0, 24'h0);
      expS(cyc + 2, 4'b0000, 3'd0, 0, 0, 1, 1, B0, B1);
      cycleIn(1, 0, 1, 0, 11'd0, 24'd0);
      idle(1);
      expS(cyc + 1, 4'b0001, 3'd0, 0, 0, 1, 0, 24'h0, 24'h0);
      expW(4'b0001, 11'd5, 24'h0BEEF0);
      cycleIn(0, 0, 0, 1, 11'd5, 24'h0BEEF0);

      // Fill to FULL, then jmp plus write while full
      for (int k = 1; k <= 4; k++) begin
         expS(cyc + 1, 4'b0000, 3'(k), (k >= 2), 0, 1, 0, 24'h0, 24'h0);
         cycleIn(1, 0, 0, 0, 11'd0, 24'd0);
      end
      expS(cyc + 1, 4'b0000, 3'd4, 1, 1, 1, 1, B0, B1);
      cycleIn(1, 0, 0, 1, 11'd9, 24'hDEAD00);

      // FULL: rdReq accepted, coincident jmp rejected
      expS(cyc + 1, 4'b0000, 3'd3, 1, 1, 1, 0, 24'h0, 24'h0);
      expS(cyc + 2, 4'b0000, 3'd3, 1, 1, 1, 1, B1, B2);
      cycleIn(1, 1, 0, 0, 11'd0, 24'd0);
      idle(1);

      // Write coinciding with frmEnd is dropped; flags kept
      expS(cyc + 1, 4'b0000, 3'd0, 0, 1, 1, 0, 24'h0, 24'h0);
      cycleIn(0, 0, 1, 1, 11'd3, 24'h777777);

      // Reset mid-line kills the in-flight write and clears flags
      cycleIn(1, 0, 0, 0, 11'd0, 24'd0);
      rst = 1'b1;
      expS(cyc + 1, 4'b0000, 3'd0, 0, 0, 0, 1, 24'h0, 24'h0);
      cycleIn(0, 0, 0, 1, 11'd2, 24'h333333);
      rst = 1'b0;

      // Read data follows ramRdData with one cycle of latency
      ramRdData = {B3, B2, 24'h5C5C5C, 24'h0F0F0F};
      expS(cyc + 1, 4'b0000, 3'd0, 0, 0, 0, 1, 24'h0F0F0F, 24'h5C5C5C);
      idle(3);

      nTests++;
      if (wq.size() != 0 || sq.size() != 0) begin
         nFail++;
         $display("FAIL queues_drained: got wr=%0d stat=%0d, expected 0/0", wq.size(), sq.size());
      end
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
